xdat_dma: RTL and testbench

- Requester (master) side of the memory peripheral bus DMA port.
- Moves a block of bytes between a peripheral byte stream (e.g. UPDPRL Rx/Tx buffer) and XDAT (0x000–0x4FF).
- Drives dma_w/dma_r/dma_addr/dma_wdat and consumes dma_ack plus xram read data.
- Programmed by SFR-side descriptor inputs; one transfer at a time.

---
 rtl/xdat_dma_pkg.sv | 27 ++
 rtl/xdat_dma_fifo2.sv | 56 +++++
 rtl/xdat_dma.sv | 181 ++++++++++++++++++
 tb/tb_xdat_dma.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xdat_dma_pkg.sv
// Shared types, constants and the CRC-8 step for the XDAT DMA requester.
// The CRC helper is only referenced when XDAT_DMA_CRC_EN is defined.
package xdat_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHK   = 3'd1,
    ST_XFER  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  localparam logic [10:0] XDAT_TOP_DEF = 11'h500;
  localparam int          FIFO_DEPTH   = 2;
  localparam logic [7:0]  CRC8_POLY    = 8'h07;

  // One byte of CRC-8, MSB first.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] data);
    logic [7:0] c;
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/xdat_dma_fifo2.sv
// Two-entry byte FIFO buffering XDAT read data toward the output stream.
// Output data reads as zero while empty.
module xdat_dma_fifo2 (
  input  logic       mclk,
  input  logic       srst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [1:0] count,
  output logic       full,
  output logic       empty
);

  logic [7:0] mem0;
  logic [7:0] mem1;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       do_push;
  logic       do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge mclk or posedge srst) begin
    if (srst) begin
      mem0   <= 8'h00;
      mem1   <= 8'h00;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        if (wr_ptr) mem1 <= din;
        else        mem0 <= din;
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign dout = empty ? 8'h00 : (rd_ptr ? mem1 : mem0);

endmodule

// File: rtl/xdat_dma.sv
// XDAT DMA requester: moves a byte block between a peripheral stream and XDAT.
// Define XDAT_DMA_CRC_EN to add a CRC-8 of every acknowledged byte on port crc.
module xdat_dma
  import xdat_dma_pkg::*;
#(
  parameter logic [10:0] XDAT_TOP = XDAT_TOP_DEF
) (
  input  logic        mclk,
  input  logic        srst,
  input  logic        cfg_start,
  input  logic        cfg_dir,
  input  logic [10:0] cfg_addr,
  input  logic [10:0] cfg_len,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        aborted,
  output logic        dma_w,
  output logic        dma_r,
  output logic [10:0] dma_addr,
  output logic [7:0]  dma_wdat,
  input  logic        dma_ack,
  input  logic [7:0]  dma_rdat,
  input  logic        s_vld,
  input  logic [7:0]  s_dat,
  output logic        s_rdy,
  output logic        m_vld,
  output logic [7:0]  m_dat,
  input  logic        m_rdy
`ifdef XDAT_DMA_CRC_EN
  ,
  output logic [7:0]  crc
`endif
);

  state_t      state;
  state_t      state_nxt;
  logic        dir_q;
  logic [10:0] addr_q;
  logic [10:0] len_q;
  logic        err_q;
  logic        aborted_q;
  logic        dma_w_q;
  logic        dma_r_q;
  logic [7:0]  hold_dat;

  logic        ack_w;
  logic        ack_r;
  logic        start_hit;
  logic        abort_hit;
  logic        range_bad;
  logic        last_ack;
  logic        s_take;
  logic        issue_r;

  logic [1:0]  fifo_count;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_flush;

  // Acks count only against the request we are actually holding up.
  assign ack_w     = dma_w_q & dma_ack;
  assign ack_r     = dma_r_q & dma_ack;
  assign start_hit = (state == ST_IDLE) & cfg_start;
  assign abort_hit = abort & ((state == ST_CHK) | (state == ST_XFER) | (state == ST_DRAIN));
  assign range_bad = ({1'b0, addr_q} + {1'b0, len_q}) > {1'b0, XDAT_TOP};
  assign last_ack  = (ack_w | ack_r) & (len_q == 11'd1);
  assign s_take    = s_vld & s_rdy;
  assign issue_r   = (state == ST_XFER) & dir_q & ~dma_r_q & (len_q != 11'd0)
                   & (int'(fifo_count) < FIFO_DEPTH) & ~abort;

  assign fifo_push  = ack_r & ~abort_hit & ~fifo_full;
  assign fifo_pop   = m_vld & m_rdy;
  assign fifo_flush = abort_hit;

  xdat_dma_fifo2 u_fifo (
    .mclk  (mclk),
    .srst  (srst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (dma_rdat),
    .dout  (m_dat),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge mclk or posedge srst) begin
    if (srst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cfg_start) state_nxt = ST_CHK;
      ST_CHK: begin
        if (abort || len_q == 11'd0 || range_bad) state_nxt = ST_FIN;
        else                                      state_nxt = ST_XFER;
      end
      ST_XFER: begin
        if (abort)         state_nxt = ST_FIN;
        else if (last_ack) state_nxt = dir_q ? ST_DRAIN : ST_FIN;
      end
      ST_DRAIN: if (abort || fifo_empty) state_nxt = ST_FIN;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Descriptor, request and sticky status registers.
  always_ff @(posedge mclk or posedge srst) begin
    if (srst) begin
      dir_q     <= 1'b0;
      addr_q    <= 11'd0;
      len_q     <= 11'd0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
      dma_w_q   <= 1'b0;
      dma_r_q   <= 1'b0;
      hold_dat  <= 8'h00;
    end else if (start_hit) begin
      dir_q     <= cfg_dir;
      addr_q    <= cfg_addr;
      len_q     <= cfg_len;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
      dma_w_q   <= 1'b0;
      dma_r_q   <= 1'b0;
    end else begin
      if ((state == ST_CHK) && !abort && (len_q != 11'd0) && range_bad) err_q <= 1'b1;
      if (ack_w || ack_r) begin
        addr_q <= addr_q + 11'd1;
        len_q  <= len_q - 11'd1;
      end
      if (abort_hit) begin
        dma_w_q   <= 1'b0;
        dma_r_q   <= 1'b0;
        aborted_q <= 1'b1;
      end else begin
        if (ack_w) begin
          dma_w_q <= 1'b0;
        end else if (s_take) begin
          dma_w_q  <= 1'b1;
          hold_dat <= s_dat;
        end
        if (ack_r)        dma_r_q <= 1'b0;
        else if (issue_r) dma_r_q <= 1'b1;
      end
    end
  end

  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_FIN);
  assign err      = err_q;
  assign aborted  = aborted_q;
  assign dma_w    = dma_w_q;
  assign dma_r    = dma_r_q;
  assign dma_addr = addr_q;
  assign dma_wdat = hold_dat;
  assign s_rdy    = (state == ST_XFER) & ~dir_q & ~dma_w_q & (len_q != 11'd0);
  assign m_vld    = ~fifo_empty;

`ifdef XDAT_DMA_CRC_EN
  logic [7:0] crc_q;

  always_ff @(posedge mclk or posedge srst) begin
    if (srst)           crc_q <= 8'h00;
    else if (start_hit) crc_q <= 8'h00;
    else if (ack_w)     crc_q <= crc8_byte(crc_q, hold_dat);
    else if (ack_r)     crc_q <= crc8_byte(crc_q, dma_rdat);
  end

  assign crc = crc_q;
`endif

endmodule

// File: tb/tb_xdat_dma.sv
// Directed self-checking bench for xdat_dma with a simple XDAT bus responder.
// Also exercises the crc port when XDAT_DMA_CRC_EN is defined.
module tb_xdat_dma;

  logic        mclk = 1'b0;
  logic        srst;
  logic        cfg_start, cfg_dir, abort;
  logic [10:0] cfg_addr, cfg_len;
  logic        busy, done, err, aborted, dma_w, dma_r;
  logic [10:0] dma_addr;
  logic [7:0]  dma_wdat, dma_rdat, s_dat, m_dat;
  logic        dma_ack, s_vld, s_rdy, m_vld, m_rdy;
`ifdef XDAT_DMA_CRC_EN
  logic [7:0]  crc;
`endif

  always #5 mclk = ~mclk;

  xdat_dma dut (
`ifdef XDAT_DMA_CRC_EN
    .crc       (crc),
`endif
    .mclk      (mclk),
    .srst      (srst),
    .cfg_start (cfg_start),
    .cfg_dir   (cfg_dir),
    .cfg_addr  (cfg_addr),
    .cfg_len   (cfg_len),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .aborted   (aborted),
    .dma_w     (dma_w),
    .dma_r     (dma_r),
    .dma_addr  (dma_addr),
    .dma_wdat  (dma_wdat),
    .dma_ack   (dma_ack),
    .dma_rdat  (dma_rdat),
    .s_vld     (s_vld),
    .s_dat     (s_dat),
    .s_rdy     (s_rdy),
    .m_vld     (m_vld),
    .m_dat     (m_dat),
    .m_rdy     (m_rdy)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]  xmem [2048];
  logic [7:0]  src_q [$];
  logic [7:0]  out_q [$];
  logic [10:0] wr_addr_q [$];
  logic [7:0]  wr_dat_q [$];
  int rd_acks, done_cnt, req_cycles, over_cnt, both_cnt, stab_bad;
  int hold_left, rd_age, used;
  bit spur_en, spur_next;
  logic prev_req, prev_ack;
  logic [10:0] prev_addr;
  logic [7:0]  prev_wdat;

  // Bit-serial CRC-8 (poly 0x07) reference.
  function automatic logic [7:0] refCrc(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[7] ^ d[i];
      r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Record the current cycle, advance one clock, then drive stream and bus responses.
  task automatic tick();
    logic hs;
    if (dma_w && dma_r) both_cnt++;
    if (dma_w || dma_r) begin
      req_cycles++;
      if (dma_addr >= 11'h500) over_cnt++;
    end
    if (prev_req && !prev_ack && (dma_w || dma_r) &&
        (dma_addr !== prev_addr || dma_wdat !== prev_wdat)) stab_bad++;
    prev_req  = dma_w || dma_r;
    prev_ack  = dma_ack;
    prev_addr = dma_addr;
    prev_wdat = dma_wdat;
    if (dma_w && dma_ack) begin
      wr_addr_q.push_back(dma_addr);
      wr_dat_q.push_back(dma_wdat);
      xmem[dma_addr] = dma_wdat;
    end
    if (dma_r && dma_ack) rd_acks++;
    if (m_vld && m_rdy) out_q.push_back(m_dat);
    if (done) done_cnt++;
    hs = s_vld && s_rdy;
    spur_next = spur_en && dma_r && dma_ack;
    @(posedge mclk);
    #1;
    if (hs) void'(src_q.pop_front());
    s_vld = (src_q.size() > 0);
    s_dat = s_vld ? src_q[0] : 8'h00;
    dma_ack  = 1'b0;
    dma_rdat = 8'h00;
    if (dma_w) begin
      if (hold_left > 0) hold_left--;
      else               dma_ack = 1'b1;
    end else if (dma_r) begin
      if (rd_age >= 1) begin
        dma_ack  = 1'b1;
        dma_rdat = xmem[dma_addr];
        rd_age   = 0;
      end else begin
        rd_age++;
      end
    end else begin
      rd_age = 0;
      if (spur_next) begin
        dma_ack  = 1'b1;
        dma_rdat = 8'hEE;
      end
    end
  endtask

  task automatic clearLogs();
    out_q.delete();
    wr_addr_q.delete();
    wr_dat_q.delete();
    rd_acks = 0; req_cycles = 0; over_cnt = 0; both_cnt = 0; stab_bad = 0;
  endtask

  task automatic applyStimulus(input logic dir, input logic [10:0] addr, input logic [10:0] len);
    clearLogs();
    cfg_dir   = dir;
    cfg_addr  = addr;
    cfg_len   = len;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget, output int n);
    int d0;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    checkOutput({tag, "_done_once"}, done_cnt - d0, 1);
  endtask

  initial begin
    logic [7:0] c;
    srst = 1'b1; cfg_start = 0; cfg_dir = 0; cfg_addr = 0; cfg_len = 0; abort = 0;
    dma_ack = 0; dma_rdat = 0; s_vld = 0; s_dat = 0; m_rdy = 0;
    hold_left = 0; rd_age = 0; spur_en = 0; spur_next = 0; done_cnt = 0;
    prev_req = 0; prev_ack = 0; prev_addr = 0; prev_wdat = 0;
    for (int i = 0; i < 2048; i++) xmem[i] = 8'h00;
    clearLogs();

    // Reset state
    repeat (2) @(posedge mclk);
    #1;
    checkOutput("reset_flags", {busy, done, err, aborted, dma_w, dma_r, s_rdy, m_vld}, 0);
    checkOutput("reset_bus", {dma_addr, dma_wdat, m_dat}, 0);
    srst = 1'b0;
    tick();

    // Write 4 bytes to 0x100
    src_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    applyStimulus(1'b0, 11'h100, 11'd4);
    waitDone("write", 60, used);
    checkOutput("write_count", wr_addr_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("write_addr%0d", i), wr_addr_q[i], 11'h100 + 11'(i));
      checkOutput($sformatf("write_data%0d", i), wr_dat_q[i], 8'hA1 + 8'(i));
    end
    checkOutput("write_busy_after", busy, 1'b0);
    checkOutput("write_err", err, 1'b0);
    checkOutput("write_no_both", both_cnt, 0);
`ifdef XDAT_DMA_CRC_EN
    c = 8'h00;
    for (int i = 0; i < 4; i++) c = refCrc(c, 8'hA1 + 8'(i));
    checkOutput("write_crc", crc, c);
`endif

    // Read 4 bytes at the very top of XDAT
    xmem[11'h4FC] = 8'h11; xmem[11'h4FD] = 8'h22; xmem[11'h4FE] = 8'h33; xmem[11'h4FF] = 8'h44;
    m_rdy = 1'b1;
    applyStimulus(1'b1, 11'h4FC, 11'd4);
    waitDone("read", 80, used);
    checkOutput("read_count", out_q.size(), 4);
    checkOutput("read_data", {out_q[0], out_q[1], out_q[2], out_q[3]}, 32'h11223344);
    checkOutput("read_no_over_top", over_cnt, 0);
    checkOutput("read_err", err, 1'b0);
`ifdef XDAT_DMA_CRC_EN
    c = refCrc(refCrc(refCrc(refCrc(8'h00, 8'h11), 8'h22), 8'h33), 8'h44);
    checkOutput("read_crc", crc, c);
`endif

    // Backpressure: only two reads may land while the consumer stalls
    for (int i = 0; i < 6; i++) xmem[11'h200 + 11'(i)] = 8'h50 + 8'(i);
    m_rdy = 1'b0;
    applyStimulus(1'b1, 11'h200, 11'd6);
    repeat (20) tick();
    checkOutput("bp_acks_stalled", rd_acks, 2);
    checkOutput("bp_dma_r_low", dma_r, 1'b0);
    checkOutput("bp_m_vld", m_vld, 1'b1);
    m_rdy = 1'b1;
    waitDone("bp", 80, used);
    checkOutput("bp_count", out_q.size(), 6);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("bp_data%0d", i), out_q[i], 8'h50 + 8'(i));

    // Range error: 0x4FE + 3 crosses the top
    applyStimulus(1'b0, 11'h4FE, 11'd3);
    waitDone("range", 10, used);
    checkOutput("range_err", err, 1'b1);
    checkOutput("range_no_req", req_cycles, 0);

    // Zero length finishes quickly and clears the error
    applyStimulus(1'b0, 11'h010, 11'd0);
    waitDone("zero", 2, used);
    checkOutput("zero_err_cleared", err, 1'b0);
    checkOutput("zero_no_req", req_cycles, 0);

    // Contention: write ack held off for 5 cycles
    src_q = '{8'h5A, 8'hA5};
    hold_left = 5;
    applyStimulus(1'b0, 11'h300, 11'd2);
    waitDone("cont", 60, used);
    checkOutput("cont_req_cycles", req_cycles, 7);
    checkOutput("cont_stable", stab_bad, 0);
    checkOutput("cont_wr", {wr_addr_q[0], wr_dat_q[0], wr_addr_q[1], wr_dat_q[1]},
                {11'h300, 8'h5A, 11'h301, 8'hA5});

    // Spurious ack after each read ack must not push
    xmem[11'h310] = 8'h31; xmem[11'h311] = 8'h32; xmem[11'h312] = 8'h33;
    spur_en = 1'b1;
    applyStimulus(1'b1, 11'h310, 11'd3);
    waitDone("spur", 60, used);
    spur_en = 1'b0;
    checkOutput("spur_count", out_q.size(), 3);
    checkOutput("spur_acks", rd_acks, 3);
    checkOutput("spur_data", {out_q[0], out_q[1], out_q[2]}, 24'h313233);

    // Abort an 8-byte read after the second byte
    for (int i = 0; i < 8; i++) xmem[i] = 8'hC0 + 8'(i);
    applyStimulus(1'b1, 11'h000, 11'd8);
    used = 0;
    while (rd_acks < 2 && used < 40) begin tick(); used++; end
    checkOutput("abort_reach_2", rd_acks, 2);
    tick();
    used = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_req_drop", {dma_w, dma_r}, 2'b00);
    checkOutput("abort_m_vld", m_vld, 1'b0);
    checkOutput("abort_s_rdy", s_rdy, 1'b0);
    checkOutput("abort_sticky", aborted, 1'b1);
    checkOutput("abort_done", done, 1'b1);
    tick();
    checkOutput("abort_done_once", done_cnt - used, 1);
    checkOutput("abort_busy_after", busy, 1'b0);
    checkOutput("abort_no_more_acks", rd_acks, 2);

    applyStimulus(1'b0, 11'h020, 11'd0);
    waitDone("zero2", 2, used);
    checkOutput("aborted_cleared", aborted, 1'b0);

    // Reset in the middle of a write
    for (int i = 0; i < 8; i++) src_q.push_back(8'h70 + 8'(i));
    applyStimulus(1'b0, 11'h080, 11'd8);
    used = 0;
    while (wr_addr_q.size() < 3 && used < 40) begin tick(); used++; end
    checkOutput("srst_reach_3", wr_addr_q.size(), 3);
    srst = 1'b1;
    #1;
    checkOutput("srst_flags", {busy, done, err, aborted, dma_w, dma_r, s_rdy, m_vld}, 0);
    checkOutput("srst_bus", {dma_addr, dma_wdat, m_dat}, 0);
    src_q.delete();
    req_cycles = 0;
    repeat (4) tick();
    checkOutput("srst_no_req", req_cycles, 0);
    srst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
